// File: rtl/spi_memory_master.sv
// SPI mode-0 initiator for the on-board memory responder: one 16-bit frame
// {addr[6:0], rw, data[7:0]} per accepted start, MSB first, read data captured from miso.
module spi_memory_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int            HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          half_end;

  assign half_end = (half_q == HALF_LAST);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = {addr, rw, (rw ? 8'h00 : wdata)};
          cs_n_d  = 1'b0;
          mosi_d  = addr[6];
          busy_d  = 1'b1;
          half_d  = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (half_end) begin
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          half_d = half_q + HW'(1);
        end else begin
          half_d = '0;
          if (sclk_q) begin
            // End of the high half: sample as late as possible, then fall and advance mosi.
            sclk_d = 1'b0;
            if (tx_q[8] && bit_q[3]) begin
              cap_d = {cap_q[6:0], miso};
            end
            if (bit_q != 4'd15) begin
              mosi_d = tx_q[4'd14 - bit_q];
            end
          end else if (bit_q == 4'd15) begin
            bit_d   = '0;
            state_d = S_HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (half_end) begin
          half_d  = '0;
          state_d = S_DONE;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_DONE: begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done_d  = 1'b1;
        half_d  = '0;
        state_d = S_GAP;
        if (tx_q[8]) begin
          rdata_d = cap_q;
        end
      end
      S_GAP: begin
        if (half_end) begin
          half_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign mosi  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule
